// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the configurable UART receiver:
//   - uart_state_t         : receiver FSM states
//   - UART_MAX_DATA_BITS   : widest supported data field
//   - UART_DEFAULT_CLK_DIV : clocks per bit for a 50 MHz clock at 9600 baud
//   - uart_parity()        : expected parity bit for a (zero-extended) data word
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } uart_state_t;

    localparam int UART_MAX_DATA_BITS   = 9;
    localparam int UART_DEFAULT_CLK_DIV = 50_000_000 / 9600;  // 5208

    // Parity bit the transmitter should have sent. Even parity makes the total
    // count of ones (data + parity) even; odd parity makes it odd. Unused upper
    // data bits must be zero.
    function automatic logic uart_parity(input logic [UART_MAX_DATA_BITS-1:0] data,
                                         input logic                          odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// -----------------------------------------------------------------------------
// uart_rx_sampler
// Line conditioning and bit timing for the UART receiver.
//   clk, rst_n  : clock, synchronous active-low reset
//   rx_i        : asynchronous serial line (idle high)
//   cnt_en      : from the FSM; high while a frame is in progress, low holds
//                 the bit counter at 0
//   start_edge  : synchronized line went 1 -> 0 (falling edge)
//   bit_tick    : decision cycle (cnt == CLK_DIV/2 + 1)
//   bit_val     : majority of the three mid-bit samples, valid with bit_tick
// -----------------------------------------------------------------------------
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int CLK_DIV = UART_DEFAULT_CLK_DIV
) (
    input  logic clk,
    input  logic rst_n,
    input  logic rx_i,
    input  logic cnt_en,
    output logic start_edge,
    output logic bit_tick,
    output logic bit_val
);

    localparam int CW = $clog2(CLK_DIV);
    localparam int H  = CLK_DIV / 2;

    localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] SMP_A   = CW'(H - 1);
    localparam logic [CW-1:0] SMP_B   = CW'(H);
    localparam logic [CW-1:0] SMP_C   = CW'(H + 1);

    logic          sync_meta;
    logic          synced;
    logic          hist;
    logic [CW-1:0] cnt;
    logic          samp_a;
    logic          samp_b;

    // NOTE: sequential state is assigned with <= so every register in the
    // block sees pre-edge values; the synchronizer chain depends on it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // History resets low, so the line must be seen high before a
            // falling edge can be reported.
            sync_meta <= 1'b0;
            synced    <= 1'b0;
            hist      <= 1'b0;
            cnt       <= '0;
            samp_a    <= 1'b0;
            samp_b    <= 1'b0;
        end else begin
            sync_meta <= rx_i;
            synced    <= sync_meta;
            hist      <= synced;

            if (!cnt_en || cnt == CNT_MAX) cnt <= '0;
            else                           cnt <= cnt + 1'b1;

            if (cnt == SMP_A) samp_a <= synced;
            if (cnt == SMP_B) samp_b <= synced;
        end
    end

    assign start_edge = hist & ~synced;
    assign bit_tick   = cnt_en && (cnt == SMP_C);
    // Third sample is the live synced value in the decision cycle.
    assign bit_val    = (samp_a & samp_b) | (samp_a & synced) | (samp_b & synced);

endmodule

// File: rtl/uart_rx_cfg.sv
// -----------------------------------------------------------------------------
// uart_rx_cfg
// Parametrised UART receiver with 3-sample majority voting and a one-entry
// valid/ready output register that reports overrun.
//
// Optional feature macro: UART_RX_PARITY_EN
//   defined   : a parity bit follows the data bits and is checked per PARITY_ODD
//   undefined : no parity bit; parity_err_o is tied to 0
//
// Parameters: CLK_DIV (clocks per bit, >= 8), DATA_BITS (5..9, LSB first),
//             STOP_BITS (1 or 2), PARITY_ODD (1 = odd, 0 = even)
// Ports:
//   clk, rst_n    : clock, synchronous active-low reset
//   rx_i          : asynchronous serial line, idle high
//   data_o        : received data, held while valid_o
//   valid_o       : frame available
//   ready_i       : consumer accepts (transfer on valid_o && ready_i)
//   frame_err_o   : a stop bit was sampled 0 (qualified by valid_o)
//   parity_err_o  : parity mismatch (qualified by valid_o)
//   overrun_o     : one-cycle pulse when a completed frame is dropped
//   busy_o        : high whenever the FSM is not idle
// -----------------------------------------------------------------------------
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int CLK_DIV    = UART_DEFAULT_CLK_DIV,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx_i,
    output logic [DATA_BITS-1:0] data_o,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic                 frame_err_o,
    output logic                 parity_err_o,
    output logic                 overrun_o,
    output logic                 busy_o
);

    localparam int IW = $clog2(DATA_BITS + 1);

    localparam logic [IW-1:0] LAST_DATA = IW'(DATA_BITS - 1);
    localparam logic [IW-1:0] LAST_STOP = IW'(STOP_BITS - 1);

    logic                 start_edge;
    logic                 bit_tick;
    logic                 bit_val;
    uart_state_t          state;
    logic [IW-1:0]        bit_idx;
    logic                 frame_err_acc;
    logic [DATA_BITS-1:0] shreg;
    logic                 stop_err;
    logic                 last_stop;
    logic                 load_ok;

    uart_rx_sampler #(
        .CLK_DIV (CLK_DIV)
    ) u_sampler (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_i       (rx_i),
        .cnt_en     (state != S_IDLE),
        .start_edge (start_edge),
        .bit_tick   (bit_tick),
        .bit_val    (bit_val)
    );

    // Frame error including the stop bit being decided right now.
    assign stop_err  = frame_err_acc | ~bit_val;
    assign last_stop = (state == S_STOP) && bit_tick && (bit_idx == LAST_STOP);
    // The output slot is free if empty or being drained this very cycle.
    assign load_ok   = !valid_o || ready_i;

`ifdef UART_RX_PARITY_EN
    localparam logic ODD = (PARITY_ODD != 0);

    logic par_err_acc;
    logic parity_err_q;
    logic par_exp;

    assign par_exp      = uart_parity(UART_MAX_DATA_BITS'(shreg), ODD);
    assign parity_err_o = parity_err_q;
`else
    assign parity_err_o = 1'b0;
`endif

    // NOTE: the shift register is not reset; every frame shifts in all
    // DATA_BITS positions before the value is used, and a reset mid-frame
    // discards the frame anyway.
    always_ff @(posedge clk) begin
        if (state == S_DATA && bit_tick) shreg <= {bit_val, shreg[DATA_BITS-1:1]};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            bit_idx       <= '0;
            frame_err_acc <= 1'b0;
            busy_o        <= 1'b0;
            data_o        <= '0;
            valid_o       <= 1'b0;
            frame_err_o   <= 1'b0;
            overrun_o     <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_err_acc   <= 1'b0;
            parity_err_q  <= 1'b0;
`endif
        end else begin
            overrun_o <= 1'b0;

            // Output stage: a handshake empties the slot unless a frame
            // completes in the same cycle and reloads it.
            if (valid_o && ready_i) valid_o <= 1'b0;
            if (last_stop) begin
                if (load_ok) begin
                    valid_o     <= 1'b1;
                    data_o      <= shreg;
                    frame_err_o <= stop_err;
`ifdef UART_RX_PARITY_EN
                    parity_err_q <= par_err_acc;
`endif
                end else begin
                    overrun_o <= 1'b1;
                end
            end

            unique case (state)
                S_IDLE: begin
                    if (start_edge) begin
                        state  <= S_START;
                        busy_o <= 1'b1;
                    end
                end
                S_START: begin
                    if (bit_tick) begin
                        if (bit_val) begin
                            // Line back high at mid start bit: a glitch.
                            state  <= S_IDLE;
                            busy_o <= 1'b0;
                        end else begin
                            state   <= S_DATA;
                            bit_idx <= '0;
                        end
                    end
                end
                S_DATA: begin
                    if (bit_tick) begin
                        if (bit_idx == LAST_DATA) begin
                            bit_idx       <= '0;
                            frame_err_acc <= 1'b0;
`ifdef UART_RX_PARITY_EN
                            state <= S_PARITY;
`else
                            state <= S_STOP;
`endif
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (bit_tick) begin
                        par_err_acc <= (bit_val != par_exp);
                        state       <= S_STOP;
                    end
                end
`endif
                S_STOP: begin
                    if (bit_tick) begin
                        if (bit_idx == LAST_STOP) begin
                            // Leave at mid stop bit so a start edge in the
                            // second half of the stop bit is not missed.
                            state  <= S_IDLE;
                            busy_o <= 1'b0;
                        end else begin
                            frame_err_acc <= stop_err;
                            bit_idx       <= bit_idx + 1'b1;
                        end
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_cfg
// Directed and randomized frames driven bit by bit onto rx_i. Expected frame
// contents, error flags and delivery cycle come from the frame that was sent;
// a negedge monitor logs every output handshake and every overrun pulse.
// -----------------------------------------------------------------------------
module tb_uart_rx_cfg;

    localparam int D    = 16;           // clocks per bit
    localparam int H    = D / 2;
    localparam int DB   = 8;
    localparam int STOP = 1;
    localparam int ODD  = 0;
`ifdef UART_RX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int NB = 1 + DB + P + STOP;    // bits per frame

    logic          clk = 1'b0;
    logic          rst_n;
    logic          rx_i;
    logic [DB-1:0] data_o;
    logic          valid_o;
    logic          ready_i;
    logic          frame_err_o;
    logic          parity_err_o;
    logic          overrun_o;
    logic          busy_o;

    uart_rx_cfg #(
        .CLK_DIV    (D),
        .DATA_BITS  (DB),
        .STOP_BITS  (STOP),
        .PARITY_ODD (ODD)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx_i         (rx_i),
        .data_o       (data_o),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .frame_err_o  (frame_err_o),
        .parity_err_o (parity_err_o),
        .overrun_o    (overrun_o),
        .busy_o       (busy_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        int            cyc;
        logic [DB-1:0] data;
        logic          fe;
        logic          pe;
    } obs_t;

    obs_t obs_q[$];
    int   ovr_cnt = 0;

    always @(negedge clk) begin
        if (rst_n === 1'b1 && valid_o === 1'b1 && ready_i === 1'b1)
            obs_q.push_back('{cyc, data_o, frame_err_o, parity_err_o});
        if (overrun_o === 1'b1) ovr_cnt++;
    end

    int compared   = 0;
    int mismatched = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one complete frame; c0 is the cycle count at the start-bit fall.
    // glitch_bit >= 0 pulls that data bit low for one clock near mid-bit.
    task automatic send_frame(input logic [DB-1:0] d, input logic stop_v,
                              input logic par_v, input int glitch_bit,
                              output int c0);
        @(posedge clk); #1;
        rx_i = 1'b0;
        c0   = cyc;
        repeat (D) @(posedge clk);
        #1;
        for (int i = 0; i < DB; i++) begin
            rx_i = d[i];
            if (i == glitch_bit) begin
                repeat (H + 1) @(posedge clk);
                #1 rx_i = 1'b0;
                @(posedge clk);
                #1 rx_i = d[i];
                repeat (D - H - 2) @(posedge clk);
                #1;
            end else begin
                repeat (D) @(posedge clk);
                #1;
            end
        end
        if (P != 0) begin
            rx_i = par_v;
            repeat (D) @(posedge clk);
            #1;
        end
        for (int s = 0; s < STOP; s++) begin
            rx_i = stop_v;
            repeat (D) @(posedge clk);
            #1;
        end
        rx_i = 1'b1;
    endtask

    // Reference: parity error when the ones count over data + parity does
    // not have the configured oddness.
    function automatic logic ref_pe(input logic [DB-1:0] d, input logic par_v);
        int ones;
        if (P == 0) return 1'b0;
        ones = $countones(d) + int'(par_v);
        return ((ones % 2) != ODD);
    endfunction

    // valid_o first seen high: one clock after the mid-point decision of the
    // last stop bit, plus the synchronizer/edge-detect latency.
    function automatic int ref_cyc(input int c0);
        return c0 + 5 + (NB - 1) * D + H;
    endfunction

    task automatic wait_obs(input int budget);
        for (int n = 0; n < budget && obs_q.size() == 0; n++) @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_frame(input string tag, input logic [DB-1:0] d,
                                input logic stop_v, input logic par_v,
                                input int c0, input bit chk_cyc);
        obs_t o;
        wait_obs(NB * D + 4 * D);
        check({tag, "_got"}, obs_q.size(), 1);
        if (obs_q.size() != 0) begin
            o = obs_q.pop_front();
            check({tag, "_data"}, o.data, d);
            check({tag, "_ferr"}, o.fe, !stop_v);
            check({tag, "_perr"}, o.pe, ref_pe(d, par_v));
            if (chk_cyc) check({tag, "_cyc"}, o.cyc, ref_cyc(c0));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int            c0;
        int            ovr0;
        logic [DB-1:0] d;
        logic          sv;
        logic          pv;
        logic          good_par;

        rst_n   = 1'b0;
        rx_i    = 1'b1;
        ready_i = 1'b1;
        idle(5);
        @(negedge clk);
        check("rst_data",  data_o, 0);
        check("rst_valid", valid_o, 0);
        check("rst_ferr",  frame_err_o, 0);
        check("rst_perr",  parity_err_o, 0);
        check("rst_ovr",   overrun_o, 0);
        check("rst_busy",  busy_o, 0);
        rst_n = 1'b1;
        idle(2 * D);

        // Clean 8N1 frame, ready held high: exactly one 1-cycle pulse.
        good_par = ^8'hA5 ^ ODD[0];
        send_frame(8'hA5, 1'b1, good_par, -1, c0);
        expect_frame("a5", 8'hA5, 1'b1, good_par, c0, 1'b1);
        idle(D);
        check("a5_single_pulse", obs_q.size(), 0);
        check("a5_valid_low", valid_o, 0);
        check("a5_busy_low", busy_o, 0);

        // False start: four low clocks, line high again by mid start bit.
        @(posedge clk); #1;
        rx_i = 1'b0;
        idle(4);
        rx_i = 1'b1;
        idle(4);
        check("fs_busy_high", busy_o, 1);
        idle(2 * D);
        check("fs_busy_low", busy_o, 0);
        check("fs_no_valid", obs_q.size(), 0);

        // Framing error, then a clean frame.
        good_par = ^8'h3C ^ ODD[0];
        send_frame(8'h3C, 1'b0, good_par, -1, c0);
        expect_frame("fe3c", 8'h3C, 1'b0, good_par, c0, 1'b1);
        idle(2 * D);
        good_par = ^8'h3D ^ ODD[0];
        send_frame(8'h3D, 1'b1, good_par, -1, c0);
        expect_frame("ok3d", 8'h3D, 1'b1, good_par, c0, 1'b1);
        idle(D);

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b0, -1, c0);
        expect_frame("par0", 8'h07, 1'b1, 1'b0, c0, 1'b0);
        idle(D);
        send_frame(8'h07, 1'b1, 1'b1, -1, c0);
        expect_frame("par1", 8'h07, 1'b1, 1'b1, c0, 1'b0);
        idle(D);
`endif

        // Overrun: consumer stalled across two frames.
        ready_i = 1'b0;
        ovr0    = ovr_cnt;
        good_par = ^8'h11 ^ ODD[0];
        send_frame(8'h11, 1'b1, good_par, -1, c0);
        idle(D);
        good_par = ^8'h22 ^ ODD[0];
        send_frame(8'h22, 1'b1, good_par, -1, c0);
        idle(D);
        @(negedge clk);
        check("ovr_pulses", ovr_cnt - ovr0, 1);
        check("ovr_valid_held", valid_o, 1);
        check("ovr_data_held", data_o, 8'h11);
        check("ovr_no_handshake", obs_q.size(), 0);
        @(posedge clk); #1;
        ready_i = 1'b1;
        good_par = ^8'h11 ^ ODD[0];
        expect_frame("ovr_acc", 8'h11, 1'b1, good_par, c0, 1'b0);
        idle(4);
        check("ovr_valid_drop", valid_o, 0);
        check("ovr_22_lost", obs_q.size(), 0);
        check("ovr_no_more", ovr_cnt - ovr0, 1);

        // Single-clock glitch at mid data bit 3 is voted out.
        good_par = ^8'hFF ^ ODD[0];
        send_frame(8'hFF, 1'b1, good_par, 3, c0);
        expect_frame("glitch", 8'hFF, 1'b1, good_par, c0, 1'b1);
        idle(D);

        // Reset in the middle of a frame abandons it silently.
        ovr0 = ovr_cnt;
        @(posedge clk); #1;
        rx_i = 1'b0;
        idle(D);
        rx_i = 1'b1;
        idle(2 * D);
        check("mid_busy_before", busy_o, 1);
        rst_n = 1'b0;
        idle(3);
        rst_n = 1'b1;
        idle(NB * D);
        check("mid_no_valid", obs_q.size(), 0);
        check("mid_no_ovr", ovr_cnt - ovr0, 0);
        check("mid_busy_after", busy_o, 0);
        check("mid_valid_low", valid_o, 0);

        // Randomized frames with occasional stop-bit and parity errors.
        for (int k = 0; k < 12; k++) begin
            d  = DB'($urandom_range(0, (1 << DB) - 1));
            sv = ($urandom_range(0, 3) != 0);
            pv = (^d ^ ODD[0]) ^ ($urandom_range(0, 3) == 0);
            send_frame(d, sv, pv, -1, c0);
            expect_frame($sformatf("rnd%0d", k), d, sv, pv, c0, 1'b1);
            idle(int'($urandom_range(1, 3)) * D);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/uart_rx_cfg.md
# uart_rx_cfg

Parametrised UART receiver: configurable clock divider, data width, stop-bit count and optional parity, with 3-sample majority voting at mid-bit. Each frame is delivered with error flags through a valid/ready output register that reports overrun. It sits between the board RX pin and the sample-loading logic feeding the FFT pipeline, and supersedes the fixed 8N1 receiver.

## Interface
- `CLK_DIV`, 5208: clocks per bit (clk_freq / baud); must be ≥ 8.
- `DATA_BITS`, 8: data bits per frame, 5..9; LSB first.
- `STOP_BITS`, 1: 1 or 2.
- `PARITY_ODD`, 0: 1 = odd parity, 0 = even; used only with `UART_RX_PARITY_EN`.
- `clk  in  1`: single clock domain.
- `rst_n  in  1`: reset, synchronous, active-low.
- `rx_i  in  1`: asynchronous serial line, idle high.
- `data_o  out  DATA_BITS`: received data, held while `valid_o`.
- `valid_o  out  1`: frame available.
- `ready_i  in  1`: consumer accepts; transfer when `valid_o && ready_i`.
- `frame_err_o  out  1`: any stop bit sampled 0; qualified by `valid_o`.
- `parity_err_o  out  1`: parity mismatch; qualified by `valid_o`; constant 0 without the macro.
- `overrun_o  out  1`: one-cycle pulse when a completed frame is dropped.
- `busy_o  out  1`: high in every state except IDLE.

## Operation
- `rx_i` passes through a 2-FF synchronizer, then a 1-FF history register. All three reset to 0, so the line must be seen high before a fall can be detected.
- Start detect: history = 1 and synced = 0 while in IDLE. Bit counter `cnt` clears to 0, and the FSM enters START.
- `cnt` runs 0..CLK_DIV-1 and wraps at each bit boundary. `H = CLK_DIV/2` (integer division).
- Sampling: the synced line is captured at `cnt` = H-1, H and H+1. The bit value is the majority of the three, decided at `cnt == H+1` (the decision cycle).
- FSM states: IDLE → START → DATA → [PARITY] → STOP → IDLE.
  - START: decision 0 → DATA. Decision 1 → IDLE (false start, nothing reported).
  - DATA: shift in DATA_BITS bits, LSB first. A bit index counter (width $clog2(DATA_BITS+1)) advances on each decision.
  - PARITY: present only with the macro. Computes the expected bit over the data bits per `PARITY_ODD`.
  - STOP: STOP_BITS decisions. Any 0 sets the frame error.
- At the last stop-bit decision, the FSM returns to IDLE immediately, so a start edge in the second half of the stop bit is caught. The completed frame goes to the output stage in the same cycle.
- Output stage is a one-entry register:
  - Loads if `!valid_o` or `valid_o && ready_i` in that cycle.
  - Otherwise the new frame is discarded, `overrun_o` pulses, and the held data is unchanged.
- Reset mid-frame abandons the frame: no `valid_o` and no `overrun_o`.

## Timing
- Reset values: `data_o` = 0, `valid_o` = 0, `frame_err_o` = 0, `parity_err_o` = 0, `overrun_o` = 0, `busy_o` = 0; FSM in IDLE; `cnt` = 0.
- Synchronizer plus edge detect: the start is recognised 3 clocks after the `rx_i` fall.
- `valid_o` rises on the clock after the last stop-bit decision cycle. It stays high until the cycle after a `ready_i` handshake, unless reloaded in that same cycle.
- Accept and load in the same cycle: `valid_o` stays high with the new data. No bubble, no overrun.
- `overrun_o` is high for exactly one cycle, aligned with the cycle `valid_o` would have loaded.
- `busy_o` goes high the clock after start detect and low the clock after the last stop-bit decision.

## Configuration
- `UART_RX_PARITY_EN` defined: PARITY state exists; a parity bit is expected after the data bits and checked per `PARITY_ODD`. A mismatch sets `parity_err_o`.
- Not defined: no parity bit is expected, and the STOP state follows the last data bit. `parity_err_o` is tied to 0, and no parity logic is synthesised.

## Structure
- Package `uart_pkg`:
  - FSM state enum.
  - `UART_MAX_DATA_BITS = 9`.
  - Function `uart_parity(data, odd)`.
  - Default `CLK_DIV` constant for 50 MHz / 9600.
- Sub-module `uart_rx_sampler`: owns the synchronizer, history register, `cnt`, and the 3-sample majority vote. It outputs `start_edge`, `bit_tick` (decision cycle) and `bit_val`, and takes `cnt_en` from the FSM. `uart_rx_cfg` holds the FSM, shift register and output stage.

## Test plan
- CLK_DIV=16, 8N1, `ready_i`=1, send 0xA5 → `valid_o` is a 1-cycle pulse with `data_o`=0xA5 and no error flags. The pulse comes 1 clock after the stop-bit decision.
- `rx_i` low for 4 clocks, then high → START decision 1, return to IDLE. `busy_o` falls, no `valid_o`.
- Send 0x3C with stop bit driven 0 → `data_o`=0x3C, `frame_err_o`=1. The next frame 0x3D is received cleanly.
- Macro on, `PARITY_ODD`=0, send 0x07 with parity bit 0 → `parity_err_o`=1. Same frame with parity 1 → `parity_err_o`=0.
- `ready_i`=0, send 0x11 then 0x22 → `data_o` holds 0x11 and `overrun_o` pulses once. Raising `ready_i` accepts 0x11, then `valid_o` drops; 0x22 is never seen.
- Single-clock low glitch at `cnt`=H during data bit 3 of 0xFF → majority vote yields 1 and `data_o`=0xFF.
